// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU slow-clock controller: operating modes and FSM states.
package cpu_clk_ctrl_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_RUN  = 2'b00;
    localparam mode_t MODE_STEP = 2'b01;
    localparam mode_t MODE_HALT = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/cpu_clk_ctrl_step_sync.sv
// Two-flop synchroniser plus rising-edge detect for an asynchronous board button.
module cpu_clk_ctrl_step_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Built only from flops, so no path from the raw button reaches the pulse.
    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Programmable 50%-duty CPU slow clock with RUN / STEP / HALT control and tick counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no period in progress, clk_o low, waiting for RUN or a step
//   ST_HIGH | high phase, half_q cycles long
//   ST_LOW  | low phase, half_q cycles long; mode decides what follows
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int DEF_HALF = 300000,
    parameter int TICK_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic              step_i,
    input  logic [CNT_W-1:0]  half_i,
    input  logic              half_we_i,
    output logic              clk_o,
    output logic              tick_o,
    output logic              busy_o,
    output logic [TICK_W-1:0] tick_cnt_o
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] half_pend;
    logic             step_pls;
    logic             phase_done;
    logic             start_high;

    cpu_clk_ctrl_step_sync u_step_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn   (step_i),
        .pulse (step_pls)
    );

    assign phase_done = (count == half_q - CNT_ONE);

    // Mode is only looked at in IDLE and at the close of LOW, so phases are never cut short.
    always_comb begin
        start_high = 1'b0;
        case (state)
            ST_IDLE: start_high = (mode_i == MODE_RUN) ||
                                  ((mode_i == MODE_STEP) && step_pls);
            ST_LOW:  start_high = phase_done && (mode_i == MODE_RUN);
            default: start_high = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            count      <= '0;
            half_q     <= CNT_W'(DEF_HALF);
            half_pend  <= CNT_W'(DEF_HALF);
            clk_o      <= 1'b0;
            tick_o     <= 1'b0;
            busy_o     <= 1'b0;
            tick_cnt_o <= '0;
        end else begin
            tick_o <= 1'b0;
            // A zero half-period would never terminate a phase; clamp to one.
            if (half_we_i) begin
                half_pend <= (half_i == '0) ? CNT_ONE : half_i;
            end
            if (start_high) begin
                state      <= ST_HIGH;
                clk_o      <= 1'b1;
                tick_o     <= 1'b1;
                busy_o     <= 1'b1;
                tick_cnt_o <= tick_cnt_o + TICK_ONE;
                half_q     <= half_pend;
                count      <= '0;
            end else begin
                case (state)
                    ST_HIGH: begin
                        if (phase_done) begin
                            state <= ST_LOW;
                            clk_o <= 1'b0;
                            count <= '0;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (phase_done) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                            count  <= '0;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                    ST_IDLE: begin
                        count <= '0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        clk_o  <= 1'b0;
                        busy_o <= 1'b0;
                        count  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed plus randomized steps against a waveform-queue reference model.
module tb_cpu_clk_ctrl;

    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 3;
    localparam int TICK_W   = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        mode_i;
    logic              step_i;
    logic [CNT_W-1:0]  half_i;
    logic              half_we_i;
    logic              clk_o;
    logic              tick_o;
    logic              busy_o;
    logic [TICK_W-1:0] tick_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a queue of upcoming clk_o levels, filled one whole period at a time.
    bit wave_q[$];
    bit m_busy;
    int m_pend;
    int m_ticks;
    bit s1, s2, s3;
    bit e_clk, e_tick, e_busy;

    cpu_clk_ctrl #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF),
        .TICK_W   (TICK_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .mode_i     (mode_i),
        .step_i     (step_i),
        .half_i     (half_i),
        .half_we_i  (half_we_i),
        .clk_o      (clk_o),
        .tick_o     (tick_o),
        .busy_o     (busy_o),
        .tick_cnt_o (tick_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        wave_q.delete();
        m_busy  = 1'b0;
        m_pend  = DEF_HALF;
        m_ticks = 0;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        e_clk = 1'b0; e_tick = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_edge();
        bit pls;
        bit launch;
        if (rst_i) begin
            model_reset();
        end else begin
            pls = s2 & ~s3;
            s3 = s2; s2 = s1; s1 = step_i;
            e_tick = 1'b0;
            if (wave_q.size() > 0) begin
                e_clk = wave_q.pop_front();
            end else begin
                if (m_busy) launch = (mode_i == 2'b00);
                else        launch = (mode_i == 2'b00) || ((mode_i == 2'b01) && pls);
                if (launch) begin
                    for (int i = 0; i < m_pend; i++) wave_q.push_back(1'b1);
                    for (int i = 0; i < m_pend; i++) wave_q.push_back(1'b0);
                    e_clk   = wave_q.pop_front();
                    e_tick  = 1'b1;
                    m_ticks = (m_ticks + 1) % (1 << TICK_W);
                end else begin
                    e_clk = 1'b0;
                end
                m_busy = launch;
            end
            e_busy = m_busy;
            if (half_we_i) m_pend = (half_i == 0) ? 1 : int'(half_i);
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert ({clk_o, tick_o, busy_o, tick_cnt_o} === {e_clk, e_tick, e_busy, m_ticks[TICK_W-1:0]})
        else begin
            miscompares++;
            $error("FAIL %s t=%0t: clk/tick/busy/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                   tag, $time, clk_o, tick_o, busy_o, tick_cnt_o,
                   e_clk, e_tick, e_busy, m_ticks[TICK_W-1:0]);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check(tag);
    endtask

    task automatic wait_tick(input int max_cyc, input string tag);
        int n = 0;
        while (tick_o !== 1'b1 && n < max_cyc) begin
            cyc(tag);
            n++;
        end
        vectors++;
        assert (tick_o === 1'b1)
        else begin
            miscompares++;
            $error("FAIL %s: tick_o got %b expected 1 within %0d cycles", tag, tick_o, max_cyc);
        end
    endtask

    // Reset lands between edges, so outputs must drop without waiting for a clock.
    task automatic async_reset(input string tag);
        #3 rst_i = 1'b1;
        #1 model_reset();
        check(tag);
        cyc(tag);
        cyc(tag);
        rst_i = 1'b0;
    endtask

    task automatic write_half(input int val, input string tag);
        half_i    = CNT_W'(val);
        half_we_i = 1'b1;
        cyc(tag);
        half_we_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; mode_i = 2'b00; step_i = 1'b0; half_i = '0; half_we_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        check("reset");
        cyc("reset_hold");
        cyc("reset_hold");
        rst_i = 1'b0;

        repeat (26) cyc("run_h3");

        wait_tick(10, "w5_sync");
        cyc("w5_midhigh");
        write_half(5, "w5_write");
        repeat (30) cyc("run_h5");
        write_half(0, "w0_write");
        repeat (12) cyc("run_h1");
        write_half(3, "w3_write");
        repeat (14) cyc("run_h3b");

        wait_tick(10, "halt_sync");
        mode_i = 2'b10;
        repeat (16) cyc("halt");

        mode_i = 2'b01;
        repeat (3) cyc("step_idle");
        step_i = 1'b1;
        repeat (10) cyc("step_press1");
        step_i = 1'b0;
        repeat (4) cyc("step_rel1");
        step_i = 1'b1;
        repeat (4) cyc("step_press2");
        step_i = 1'b0;
        cyc("step_rel2");
        step_i = 1'b1;
        repeat (3) cyc("step_busy_press");
        step_i = 1'b0;
        repeat (10) cyc("step_done");

        mode_i = 2'b00;
        wait_tick(20, "rst_sync");
        cyc("rst_count1");
        async_reset("rst_mid_high");
        repeat (20) cyc("run_after_rst");

        write_half(1, "w1_write");
        repeat (40) cyc("wrap");

        repeat (700) begin
            if ($urandom_range(0, 15) == 0) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)  step_i = ~step_i;
            half_we_i = ($urandom_range(0, 9) == 0);
            half_i    = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
            cyc("rand");
        end
        half_we_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
